// File: rtl/ipml_fifo_pkg.sv
// Shared helpers for the width-converting sync FIFO: constant log2, legal-ratio
// check and derived widths computed from the top-level parameters.
package ipml_fifo_pkg;

  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin end
    return r;
  endfunction

  function automatic bit ratio_ok(input int ratio);
    return (ratio == 1) || (ratio == 2) || (ratio == 4) || (ratio == 8);
  endfunction

  function automatic int wr_w(input int rd_w, input int ratio);
    return rd_w * ratio;
  endfunction

  function automatic int rd_depth(input int ratio, input int depth_w);
    return ratio << depth_w;
  endfunction

  function automatic int lvl_w(input int ratio, input int depth_w);
    return clog2(rd_depth(ratio, depth_w)) + 1;
  endfunction

endpackage

// File: rtl/ipml_sync_fifo_wc_ram.sv
// Simple dual-port storage array, one clock, registered read data
// (the read register also acts as the FWFT prefetch register).
module ipml_sync_fifo_wc_ram #(
  parameter int DW = 32,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)    rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ipml_sync_fifo_wc.sv
// Single-clock FIFO, wide write / narrow read (c_RATIO slices per word, LSB first).
// IPML_SYNC_FIFO_FWFT_EN selects first-word-fall-through output; default is registered read.
module ipml_sync_fifo_wc
  import ipml_fifo_pkg::*;
#(
  parameter int c_RD_DATA_WIDTH    = 16,
  parameter int c_RATIO            = 2,
  parameter int c_WR_DEPTH_WIDTH   = 10,
  parameter int c_ALMOST_FULL_NUM  = 2040,
  parameter int c_ALMOST_EMPTY_NUM = 4
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [wr_w(c_RD_DATA_WIDTH, c_RATIO)-1:0]     wr_data,
  input  logic                                          wr_en,
  output logic                                          wr_full,
  output logic                                          almost_full,
  output logic                                          wr_overflow,
  output logic [c_RD_DATA_WIDTH-1:0]                    rd_data,
  input  logic                                          rd_en,
  output logic                                          rd_empty,
  output logic                                          almost_empty,
  output logic                                          rd_underflow,
  output logic [lvl_w(c_RATIO, c_WR_DEPTH_WIDTH)-1:0]   rd_water_level
);

  localparam int WRW = wr_w(c_RD_DATA_WIDTH, c_RATIO);
  localparam int RDD = rd_depth(c_RATIO, c_WR_DEPTH_WIDTH);
  localparam int LVW = lvl_w(c_RATIO, c_WR_DEPTH_WIDTH);
  localparam int SH  = clog2(c_RATIO);
  localparam int RPW = c_WR_DEPTH_WIDTH + SH;
  localparam int SLW = (SH == 0) ? 1 : SH;

  if (!ratio_ok(c_RATIO)) begin : g_bad_ratio
    $error("ipml_sync_fifo_wc: c_RATIO must be 1, 2, 4 or 8");
  end

  logic [c_WR_DEPTH_WIDTH-1:0] wptr_q;
  logic [RPW-1:0]              rptr_q;
  logic [SLW-1:0]              sel_q;
  logic [LVW-1:0]              cnt_q, cnt_d;
  logic wr_full_q, af_q, rd_empty_q, ae_q, ovf_q, udf_q;
  logic wr_acc, rd_acc, ram_re, empty_d;
  logic [WRW-1:0]                              ram_rdata;
  logic [c_RATIO-1:0][c_RD_DATA_WIDTH-1:0]     slices;

  always_comb begin
    wr_acc = wr_en & ~wr_full_q;
    rd_acc = rd_en & ~rd_empty_q;
    cnt_d  = cnt_q + (wr_acc ? LVW'(c_RATIO) : '0) - (rd_acc ? LVW'(1) : '0);
`ifdef IPML_SYNC_FIFO_FWFT_EN
    // The RAM output register is the prefetch slot; refill it whenever it is
    // free (or being popped) and the array still holds an unread slice.
    ram_re  = (cnt_q > LVW'(~rd_empty_q)) & (rd_empty_q | rd_acc);
    empty_d = ~(ram_re | (~rd_empty_q & ~rd_acc));
`else
    ram_re  = rd_acc;
    empty_d = (cnt_d == '0);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      sel_q      <= '0;
      cnt_q      <= '0;
      wr_full_q  <= 1'b0;
      af_q       <= 1'b0;
      rd_empty_q <= 1'b1;
      ae_q       <= 1'b1;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      if (wr_acc) wptr_q <= wptr_q + 1'b1;
      if (ram_re) begin
        rptr_q <= rptr_q + 1'b1;
        sel_q  <= SLW'(rptr_q & RPW'(c_RATIO - 1));
      end
      cnt_q      <= cnt_d;
      wr_full_q  <= cnt_d > LVW'(RDD - c_RATIO);
      af_q       <= int'(cnt_d) >= c_ALMOST_FULL_NUM;
      ae_q       <= int'(cnt_d) <= c_ALMOST_EMPTY_NUM;
      rd_empty_q <= empty_d;
      ovf_q      <= wr_en & wr_full_q;
      udf_q      <= rd_en & rd_empty_q;
    end
  end

  ipml_sync_fifo_wc_ram #(.DW(WRW), .AW(c_WR_DEPTH_WIDTH)) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (wr_acc),
    .waddr_i (wptr_q),
    .wdata_i (wr_data),
    .re_i    (ram_re),
    .raddr_i (rptr_q[RPW-1:SH]),
    .rdata_o (ram_rdata)
  );

  assign slices         = ram_rdata;
  assign rd_data        = slices[sel_q];
  assign wr_full        = wr_full_q;
  assign almost_full    = af_q;
  assign wr_overflow    = ovf_q;
  assign rd_empty       = rd_empty_q;
  assign almost_empty   = ae_q;
  assign rd_underflow   = udf_q;
  assign rd_water_level = cnt_q;

endmodule
